// File: rtl/aes_128_keyram_pkg.sv
// Shared constants and FSM encodings for the AES-128 round-key RAM controller.
// Contents:
//   N_ROUNDS  - round keys read per AES block
//   N_BEATS   - 64-bit write beats per expanded key (two per round key)
//   RND_W     - width of the round index
//   wr_state_t / rd_state_t - write and read FSM state encodings
package aes_128_keyram_pkg;

    localparam int N_ROUNDS = 11;
    localparam int N_BEATS  = 2 * N_ROUNDS;
    localparam int RND_W    = 4;
    localparam int BEAT_W   = 5;

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_BURST = 2'd1,
        W_DONE  = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RUN  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/aes_128_keyram_rd_seq.sv
// Read sequencer: paces one key_ready strobe every ROUND_CYC cycles for
// N_ROUNDS rounds, then pulses blk_done.
// Ports:
//   clk, kill            - clock, synchronous active-high reset
//   blk_start, key_avail - start request, qualified by a key being present
//   blk_busy             - sequence in progress
//   key_ready, rnd_idx   - keyram read strobe and the round it fetches
//   blk_done             - one-cycle pulse after the last round's final phase
module aes_128_keyram_rd_seq
    import aes_128_keyram_pkg::*;
#(
    parameter int ROUND_CYC = 3
) (
    input  logic             clk,
    input  logic             kill,
    input  logic             blk_start,
    input  logic             key_avail,
    output logic             blk_busy,
    output logic             key_ready,
    output logic [RND_W-1:0] rnd_idx,
    output logic             blk_done
);

    localparam int PH_W = $clog2(ROUND_CYC);

    rd_state_t        st, st_nx;
    logic [RND_W-1:0] rnd;
    logic [PH_W-1:0]  ph;
    logic             ph_last;
    logic             seq_last;

    always_comb begin
        ph_last  = (ph == PH_W'(ROUND_CYC - 1));
        seq_last = (st == R_RUN) && ph_last && (rnd == RND_W'(N_ROUNDS - 1));
    end

    always_ff @(posedge clk) begin
        if (kill) st <= R_IDLE;
        else      st <= st_nx;
    end

    always_comb begin
        st_nx = st;
        case (st)
            R_IDLE:  if (blk_start && key_avail) st_nx = R_RUN;
            R_RUN:   if (seq_last)               st_nx = R_IDLE;
            default: st_nx = R_IDLE;
        endcase
    end

    // Counters sit at zero while idle, so a new block always begins at
    // round 0 / phase 0 in its first busy cycle.
    always_ff @(posedge clk) begin
        if (kill || st != R_RUN) begin
            rnd <= '0;
            ph  <= '0;
        end else if (ph_last) begin
            ph  <= '0;
            rnd <= (rnd == RND_W'(N_ROUNDS - 1)) ? '0 : rnd + 1'b1;
        end else begin
            ph  <= ph + 1'b1;
        end
    end

    // Registered so the done pulse lands in the first idle cycle, which is
    // also the earliest cycle a back-to-back start can be accepted.
    always_ff @(posedge clk) begin
        if (kill) blk_done <= 1'b0;
        else      blk_done <= seq_last;
    end

    always_comb begin
        blk_busy  = (st == R_RUN);
        key_ready = (st == R_RUN) && (ph == '0);
        rnd_idx   = rnd;
    end

endmodule

// File: rtl/aes_128_keyram_ctrl.sv
// Sequencing controller for the two-bank AES-128 round-key RAM.
// Write path: accepts N_BEATS 64-bit beats from the host and streams them to
// the keyram write port. Read path: paces key_ready strobes for one AES block.
// Ports:
//   clk, kill                        - clock, synchronous active-high reset
//   key_valid/key_data/key_accept    - host key-beat handshake
//   key_loaded                       - pulse when a full key has been written
//   key_avail                        - a complete key is held since reset
//   blk_start/blk_busy/blk_done      - engine block-sequence control
//   rnd_idx                          - round index for the key_ready pulse
//   en_wr/key_round_wr               - keyram write port
//   key_ready                        - keyram read strobe
//   wr_idle                          - keyram can take a new write burst
module aes_128_keyram_ctrl
    import aes_128_keyram_pkg::*;
#(
    parameter int ROUND_CYC = 3
) (
    input  logic             clk,
    input  logic             kill,
    input  logic             key_valid,
    input  logic [63:0]      key_data,
    output logic             key_accept,
    output logic             key_loaded,
    output logic             key_avail,
    input  logic             blk_start,
    output logic             blk_busy,
    output logic [RND_W-1:0] rnd_idx,
    output logic             blk_done,
    output logic             en_wr,
    output logic [63:0]      key_round_wr,
    output logic             key_ready,
    input  logic             wr_idle
);

    wr_state_t         wst, wst_nx;
    logic [BEAT_W-1:0] beat_cnt;
    logic              hs;

    always_ff @(posedge clk) begin
        if (kill) wst <= W_IDLE;
        else      wst <= wst_nx;
    end

    // The idle->burst transition consumes no beat; accept only rises once
    // the FSM is already in W_BURST.
    always_comb begin
        wst_nx = wst;
        case (wst)
            W_IDLE:  if (key_valid && wr_idle) wst_nx = W_BURST;
            W_BURST: if (hs && beat_cnt == BEAT_W'(N_BEATS - 1)) wst_nx = W_DONE;
            W_DONE:  wst_nx = W_IDLE;
            default: wst_nx = W_IDLE;
        endcase
    end

    always_comb begin
        key_accept = (wst == W_BURST);
        key_loaded = (wst == W_DONE);
        hs         = key_valid && key_accept;
    end

    always_ff @(posedge clk) begin
        if (kill || wst != W_BURST) beat_cnt <= '0;
        else if (hs)                beat_cnt <= beat_cnt + 1'b1;
    end

    // Write port is a one-cycle-delayed copy of the handshake; data is
    // forced to zero on non-write cycles.
    always_ff @(posedge clk) begin
        if (kill) begin
            en_wr        <= 1'b0;
            key_round_wr <= '0;
        end else begin
            en_wr        <= hs;
            key_round_wr <= hs ? key_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (kill)               key_avail <= 1'b0;
        else if (wst == W_DONE) key_avail <= 1'b1;
    end

    aes_128_keyram_rd_seq #(
        .ROUND_CYC (ROUND_CYC)
    ) u_rd_seq (
        .clk       (clk),
        .kill      (kill),
        .blk_start (blk_start),
        .key_avail (key_avail),
        .blk_busy  (blk_busy),
        .key_ready (key_ready),
        .rnd_idx   (rnd_idx),
        .blk_done  (blk_done)
    );

endmodule

// File: tb/tb_aes_128_keyram_ctrl.sv
// Scoreboard bench for aes_128_keyram_ctrl. Drivers push expected timed
// events (write beats, read strobes, load/done pulses) into queues; a
// negedge monitor pops and compares whenever the DUT presents an output.
module tb_aes_128_keyram_ctrl;

    localparam int RC  = 3;
    localparam int NR  = 11;
    localparam int NB  = 22;
    localparam int INF = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        kill, key_valid, blk_start, wr_idle;
    logic [63:0] key_data;
    logic        key_accept, key_loaded, key_avail, blk_busy, blk_done;
    logic        en_wr, key_ready;
    logic [3:0]  rnd_idx;
    logic [63:0] key_round_wr;

    aes_128_keyram_ctrl #(.ROUND_CYC(RC)) dut (
        .clk(clk), .kill(kill), .key_valid(key_valid), .key_data(key_data),
        .key_accept(key_accept), .key_loaded(key_loaded), .key_avail(key_avail),
        .blk_start(blk_start), .blk_busy(blk_busy), .rnd_idx(rnd_idx),
        .blk_done(blk_done), .en_wr(en_wr), .key_round_wr(key_round_wr),
        .key_ready(key_ready), .wr_idle(wr_idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int t; logic [63:0] d; } ev_t;
    ev_t wq[$];
    ev_t rq[$];
    int  lq[$];
    int  dq[$];

    int  cmp_n = 0, err_n = 0;
    bit  mon_en = 0;

    // Behavioural model state: key availability window and busy window.
    int avail_from = INF, avail_to = INF;
    int busy_lo = -1, busy_hi = -2;

    function automatic bit exp_avail(input int c);
        return (c >= avail_from) && (c < avail_to);
    endfunction

    function automatic bit exp_busy(input int c);
        return (c >= busy_lo) && (c <= busy_hi);
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        cmp_n++;
        if (got !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Kill in cycle c: everything scheduled after c is abandoned.
    task automatic do_kill(input int c);
        kill = 1'b1;
        while (wq.size() > 0 && wq[$].t > c) void'(wq.pop_back());
        while (rq.size() > 0 && rq[$].t > c) void'(rq.pop_back());
        while (lq.size() > 0 && lq[$]   > c) void'(lq.pop_back());
        while (dq.size() > 0 && dq[$]   > c) void'(dq.pop_back());
        if (busy_hi > c) busy_hi = c;
        if (avail_from > c)        avail_from = INF;
        else if (avail_to > c + 1) avail_to   = c + 1;
    endtask

    task automatic start_block;
        int c = cyc;
        blk_start = 1'b1;
        if (exp_avail(c) && !exp_busy(c)) begin
            for (int k = 0; k < NR; k++) rq.push_back(ev_t'{c + 1 + k * RC, 64'(k)});
            dq.push_back(c + 1 + NR * RC);
            busy_lo = c + 1;
            busy_hi = c + NR * RC;
        end
        tick;
        blk_start = 1'b0;
    endtask

    // hold: cycles of wr_idle=0 with key_valid=1 before release.
    // gap_at/gap_len: drop key_valid before beat gap_at. kill_at: kill before that beat.
    task automatic load_key(input int hold, input int gap_at, input int gap_len,
                            input int kill_at, input bit contig);
        int idx = 0, gap_left = gap_len, t_req = 0, guard = 0;
        bit started = 0, first = 1;
        int c;
        while (idx < NB) begin
            c = cyc;
            if (++guard > 400) begin
                chk("load_timeout", 1, 0);
                break;
            end
            key_data = contig ? 64'(idx) : {$urandom, $urandom};
            if (hold > 0) begin
                hold--;
                wr_idle   = 1'b0;
                key_valid = 1'b1;
                chk("accept_gated", key_accept, 0);
                tick;
                continue;
            end
            wr_idle = started ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx == kill_at) begin
                key_valid = 1'b0;
                do_kill(c);
                tick;
                kill = 1'b0;
                break;
            end
            if (idx == gap_at && gap_left > 0) begin
                gap_left--;
                key_valid = 1'b0;
            end else begin
                key_valid = 1'b1;
            end
            if (!started && key_valid) begin
                started = 1;
                t_req   = c;
            end
            if (key_accept && first) begin
                chk("first_accept_cyc", 64'(c), 64'(t_req + 1));
                first = 0;
            end
            if (key_valid && key_accept) begin
                wq.push_back(ev_t'{c + 1, key_data});
                idx++;
                if (idx == NB) begin
                    lq.push_back(c + 1);
                    if (avail_from == INF || avail_to != INF) begin
                        avail_from = c + 2;
                        avail_to   = INF;
                    end
                end
            end
            tick;
        end
        key_valid = 1'b0;
        wr_idle   = 1'b1;
        tick;
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin : mon
            ev_t e;
            int  c;
            c = cyc;
            if (en_wr) begin
                if (wq.size() == 0) chk("en_wr_unexpected", en_wr, 0);
                else begin
                    e = wq.pop_front();
                    chk("en_wr_cyc", 64'(c), 64'(e.t));
                    chk("wr_data", key_round_wr, e.d);
                end
            end else begin
                chk("wr_data_idle", key_round_wr, 0);
                if (wq.size() > 0 && wq[0].t <= c) begin
                    void'(wq.pop_front());
                    chk("en_wr_missing", en_wr, 1);
                end
            end
            if (key_ready) begin
                if (rq.size() == 0) chk("key_ready_unexpected", key_ready, 0);
                else begin
                    e = rq.pop_front();
                    chk("key_ready_cyc", 64'(c), 64'(e.t));
                    chk("rnd_idx", 64'(rnd_idx), e.d);
                end
            end else if (rq.size() > 0 && rq[0].t <= c) begin
                void'(rq.pop_front());
                chk("key_ready_missing", key_ready, 1);
            end
            if (key_loaded) begin
                if (lq.size() == 0) chk("key_loaded_unexpected", key_loaded, 0);
                else chk("key_loaded_cyc", 64'(c), 64'(lq.pop_front()));
            end else if (lq.size() > 0 && lq[0] <= c) begin
                void'(lq.pop_front());
                chk("key_loaded_missing", key_loaded, 1);
            end
            if (blk_done) begin
                if (dq.size() == 0) chk("blk_done_unexpected", blk_done, 0);
                else chk("blk_done_cyc", 64'(c), 64'(dq.pop_front()));
            end else if (dq.size() > 0 && dq[0] <= c) begin
                void'(dq.pop_front());
                chk("blk_done_missing", blk_done, 1);
            end
            chk("key_avail", key_avail, 64'(exp_avail(c)));
            chk("blk_busy", blk_busy, 64'(exp_busy(c)));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        kill = 1'b1; key_valid = 1'b0; key_data = '0; blk_start = 1'b1; wr_idle = 1'b1;

        // Reset: outputs quiet, start request ignored.
        repeat (3) begin
            tick;
            mon_en = 1;
            chk("rst_outs", {key_accept, key_loaded, key_avail, blk_busy, blk_done,
                             en_wr, key_ready, rnd_idx}, 0);
            chk("rst_wr_data", key_round_wr, 0);
        end
        kill = 1'b0;
        blk_start = 1'b0;
        start_block;
        repeat (5) tick;
        chk("no_key_no_busy", blk_busy, 0);

        // Contiguous load of 0x00..0x15.
        load_key(0, -1, 0, -1, 1);
        repeat (3) tick;

        // Single block with an ignored restart at T0+5.
        t0 = cyc;
        start_block;
        repeat (4) tick;
        chk("restart_cyc", 64'(cyc), 64'(t0 + 5));
        start_block;
        repeat (35) tick;

        // Concurrent read and write, plus a back-to-back block at T0+34.
        fork
            begin
                start_block;
                repeat (33) tick;
                start_block;
            end
            begin
                repeat (3) tick;
                load_key(0, 7, 2, -1, 0);
            end
        join
        repeat (40) tick;

        // wr_idle gating.
        load_key(4, -1, 0, -1, 0);
        repeat (3) tick;

        // Kill at round 5, then kill at beat 10, then a normal load.
        t0 = cyc;
        start_block;
        repeat (15) tick;
        chk("kill_round5_idx", 64'(rnd_idx), 5);
        do_kill(cyc);
        tick;
        kill = 1'b0;
        chk("kill_rd_ready", key_ready, 0);
        chk("kill_rd_avail", key_avail, 0);
        repeat (3) tick;
        load_key(0, -1, 0, 10, 0);
        chk("kill_wr_en", en_wr, 0);
        chk("kill_wr_avail", key_avail, 0);
        repeat (3) tick;
        load_key(0, -1, 0, -1, 0);
        repeat (3) tick;

        // Randomized concurrent traffic.
        repeat (6) begin
            fork
                repeat (3) begin
                    repeat ($urandom_range(0, 20)) tick;
                    start_block;
                end
                load_key($urandom_range(0, 3), $urandom_range(0, NB - 1),
                         $urandom_range(0, 3), -1, 0);
            join
        end
        repeat (60) tick;
        chk("queues_drained", 64'(wq.size() + rq.size() + lq.size() + dq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
